// File: rtl/dual_port_ram_sync_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dual_port_ram_sync_if                                          |
// | Brief   : Write/read request bundle for the synchronous dual-port RAM.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface dual_port_ram_sync_if #(
    parameter int DATA_RAM_WIDTH = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int BYTE_WIDTH     = 8
);
    localparam int c_nb = DATA_RAM_WIDTH / BYTE_WIDTH;

    logic                      wr_en;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [DATA_RAM_WIDTH-1:0] wr_data;
    logic [c_nb-1:0]           wr_be;
    logic                      rd_en;
    logic [ADDR_WIDTH-1:0]     rd_addr;
    logic [DATA_RAM_WIDTH-1:0] rd_data;
    logic                      rd_valid;
    logic                      init_busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, init_busy
    );
endinterface
`default_nettype wire

// File: rtl/dual_port_ram_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dual_port_ram_sync                                             |
// | Brief   : Simple dual-port RAM, byte enables, 1/2-cycle read latency,    |
// |           selectable read-during-write policy, post-reset clear sweep.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dual_port_ram_sync #(
    parameter int DATA_RAM_WIDTH = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    dual_port_ram_sync_if.slave  bus
);
    localparam int   c_nb       = DATA_RAM_WIDTH / BYTE_WIDTH;
    localparam int   c_depth    = 1 << ADDR_WIDTH;
    localparam logic c_clear_en = (CLEAR_ON_RESET != 0);

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("dual_port_ram_sync: READ_LATENCY must be 1 or 2");
        end
        if (DATA_RAM_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
            $error("dual_port_ram_sync: DATA_RAM_WIDTH must be a multiple of BYTE_WIDTH");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [ADDR_WIDTH-1:0]     r_clr_cnt;
    logic [ADDR_WIDTH-1:0]     w_clr_cnt_nxt;

    logic [DATA_RAM_WIDTH-1:0] r_mem [c_depth];

    logic                      w_busy;
    logic                      w_clr_we;
    logic                      w_wr_acc;
    logic                      w_rd_acc;
    logic [DATA_RAM_WIDTH-1:0] w_rd_mem;
    logic [DATA_RAM_WIDTH-1:0] w_rd_merged;
    logic [DATA_RAM_WIDTH-1:0] w_rd_word;
    logic [DATA_RAM_WIDTH-1:0] r_s1_data;
    logic                      r_s1_valid;

    // Busy is forced during reset so requests are blocked before the first edge.
    assign w_busy   = (r_state == S_CLEAR) | (reset & c_clear_en);
    assign w_clr_we = (r_state == S_CLEAR) & ~reset;
    assign w_wr_acc = bus.wr_en & ~w_busy & ~reset;
    assign w_rd_acc = bus.rd_en & ~w_busy & ~reset;
    assign bus.init_busy = w_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_clear_en ? S_CLEAR : S_IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            S_CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
                if (&r_clr_cnt) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_acc) begin
            for (int i = 0; i < c_nb; i++) begin
                if (bus.wr_be[i]) begin
                    r_mem[bus.wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Write-first view of the read word: enabled lanes of a colliding write overlay the stored word.
    assign w_rd_mem = r_mem[bus.rd_addr];

    always_comb begin
        w_rd_merged = w_rd_mem;
        for (int i = 0; i < c_nb; i++) begin
            if (w_wr_acc && (bus.wr_addr == bus.rd_addr) && bus.wr_be[i]) begin
                w_rd_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    assign w_rd_word = (RDW_MODE == 1) ? w_rd_merged : w_rd_mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_RAM_WIDTH-1:0] r_s2_data;
            logic                      r_s2_valid;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s2_data  <= '0;
                    r_s2_valid <= 1'b0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign bus.rd_data  = r_s2_data;
            assign bus.rd_valid = r_s2_valid;
        end else begin : g_lat1
            assign bus.rd_data  = r_s1_data;
            assign bus.rd_valid = r_s1_valid;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_dual_port_ram_sync                                          |
// | Brief   : Scoreboard bench; two RAMs (latency 1/old-data, latency 2/     |
// |           new-data) driven with identical directed stimulus.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dual_port_ram_sync;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int BW    = 8;
    localparam int NB    = DW / BW;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dual_port_ram_sync_if #(.DATA_RAM_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) bus_a ();
    dual_port_ram_sync_if #(.DATA_RAM_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) bus_b ();

    dual_port_ram_sync #(
        .DATA_RAM_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW),
        .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    dual_port_ram_sync #(
        .DATA_RAM_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW),
        .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          qa[$];
    exp_t          qb[$];
    exp_t          ea;
    exp_t          eb;
    logic [DW-1:0] model [DEPTH];
    int            checks   = 0;
    int            errors   = 0;
    int            edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic wen, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic [NB-1:0] be, input logic ren, input logic [AW-1:0] ra);
        bus_a.wr_en = wen; bus_a.wr_addr = wa; bus_a.wr_data = wd; bus_a.wr_be = be;
        bus_a.rd_en = ren; bus_a.rd_addr = ra;
        bus_b.wr_en = wen; bus_b.wr_addr = wa; bus_b.wr_data = wd; bus_b.wr_be = be;
        bus_b.rd_en = ren; bus_b.rd_addr = ra;
    endtask

    // One request cycle: drive at the falling edge, update the model, queue expected results.
    task automatic step(input logic wen, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [NB-1:0] be, input logic ren, input logic [AW-1:0] ra);
        logic [DW-1:0] old_w;
        logic [DW-1:0] new_w;
        exp_t          e;
        @(negedge clk);
        set_inputs(wen, wa, wd, be, ren, ra);
        old_w = model[ra];
        if (wen) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) model[wa][i*BW +: BW] = wd[i*BW +: BW];
            end
        end
        new_w = model[ra];
        if (ren) begin
            e.data = old_w; e.due = edge_cnt + 1; qa.push_back(e);
            e.data = new_w; e.due = edge_cnt + 2; qb.push_back(e);
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic check_sweep(input string tag);
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            if (k == DEPTH) set_inputs(1'b0, '0, '0, '0, 1'b0, '0);
            check({tag, "_busy_a"}, DW'(bus_a.init_busy), DW'(k < DEPTH));
            check({tag, "_busy_b"}, DW'(bus_b.init_busy), DW'(k < DEPTH));
        end
    endtask

    always @(negedge clk) begin
        if (bus_a.rd_valid === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_unexpected_valid", DW'(bus_a.rd_valid), '0);
            end else begin
                ea = qa.pop_front();
                check("a_rd_data", bus_a.rd_data, ea.data);
                check("a_latency", DW'(edge_cnt), DW'(ea.due));
            end
        end
        if (bus_b.rd_valid === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_unexpected_valid", DW'(bus_b.rd_valid), '0);
            end else begin
                eb = qb.pop_front();
                check("b_rd_data", bus_b.rd_data, eb.data);
                check("b_latency", DW'(edge_cnt), DW'(eb.due));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        set_inputs(1'b0, '0, '0, '0, 1'b0, '0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_rd_data_a", bus_a.rd_data, '0);
        check("rst_rd_valid_a", DW'(bus_a.rd_valid), '0);
        check("rst_busy_a", DW'(bus_a.init_busy), DW'(1));
        check("rst_rd_data_b", bus_b.rd_data, '0);
        check("rst_busy_b", DW'(bus_b.init_busy), DW'(1));

        // Requests held during the whole sweep must be ignored.
        reset = 1'b0;
        set_inputs(1'b1, '0, 32'hFFFF_FFFF, '1, 1'b1, '0);
        check_sweep("sweep");

        for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, '0, 1'b1, AW'(a));
        repeat (3) idle();

        step(1'b1, 4'd5, 32'hAABB_CCDD, 4'b1111, 1'b0, '0);
        step(1'b1, 4'd5, 32'h1122_3344, 4'b0101, 1'b0, '0);
        step(1'b1, 4'd6, 32'h5555_5555, 4'b0000, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd5);
        step(1'b0, '0, '0, '0, 1'b1, 4'd6);
        repeat (2) idle();
        check("be_word_b", bus_b.rd_data, 32'h0000_0000);
        step(1'b0, '0, '0, '0, 1'b1, 4'd5);
        repeat (2) idle();
        check("be_word_a", bus_a.rd_data, 32'hAA22_CC44);
        check("be_word_b2", bus_b.rd_data, 32'hAA22_CC44);

        step(1'b1, 4'd3, 32'h0000_0012, 4'b1111, 1'b0, '0);
        step(1'b1, 4'd3, 32'h0000_0034, 4'b1111, 1'b1, 4'd3);
        repeat (2) idle();
        check("rdw_old_a", bus_a.rd_data, 32'h0000_0012);
        check("rdw_new_b", bus_b.rd_data, 32'h0000_0034);

        step(1'b1, 4'd7, 32'hAABB_CCDD, 4'b1111, 1'b0, '0);
        step(1'b1, 4'd7, 32'h1122_3344, 4'b0010, 1'b1, 4'd7);
        step(1'b1, 4'd8, 32'hDEAD_BEEF, 4'b1111, 1'b1, 4'd9);
        repeat (2) idle();

        step(1'b1, 4'd0, 32'h0000_00A0, 4'b1111, 1'b0, '0);
        step(1'b1, 4'd1, 32'h0000_00A1, 4'b1111, 1'b0, '0);
        step(1'b1, 4'd2, 32'h0000_00A2, 4'b1111, 1'b0, '0);
        repeat (2) idle();
        step(1'b0, '0, '0, '0, 1'b1, 4'd0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd1);
        step(1'b0, '0, '0, '0, 1'b1, 4'd2);
        repeat (3) idle();

        step(1'b1, AW'(DEPTH - 1), 32'h0000_00FF, 4'b1111, 1'b0, '0);
        step(1'b1, 4'd0, 32'h0000_0001, 4'b1111, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, AW'(DEPTH - 1));
        step(1'b0, '0, '0, '0, 1'b1, 4'd0);
        repeat (2) idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_data_a", bus_a.rd_data, 32'h0000_0001);
            check("hold_valid_a", DW'(bus_a.rd_valid), '0);
            check("hold_data_b", bus_b.rd_data, 32'h0000_0001);
            check("hold_valid_b", DW'(bus_b.rd_valid), '0);
        end

        // Reset partway through a sweep must restart it from address 0.
        reset = 1'b1;
        @(negedge clk);
        check("rst2_rd_data_a", bus_a.rd_data, '0);
        check("rst2_rd_data_b", bus_b.rd_data, '0);
        reset = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy_a", DW'(bus_a.init_busy), DW'(1));
        reset = 1'b1;
        @(negedge clk);
        check("mid_rd_data_a", bus_a.rd_data, '0);
        check("mid_rd_valid_a", DW'(bus_a.rd_valid), '0);
        check("mid_rd_valid_b", DW'(bus_b.rd_valid), '0);
        check("mid_busy_b", DW'(bus_b.init_busy), DW'(1));
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        reset = 1'b0;
        check_sweep("resweep");

        step(1'b0, '0, '0, '0, 1'b1, AW'(DEPTH - 1));
        step(1'b0, '0, '0, '0, 1'b1, 4'd5);
        step(1'b0, '0, '0, '0, 1'b1, 4'd0);
        for (int i = 0; i < 10; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            idle();
        end
        check("qa_drained", DW'(qa.size()), '0);
        check("qb_drained", DW'(qb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dual_port_ram_sync.md
Name: dual_port_ram_sync

Overview:
- Synchronous simple dual-port RAM: one write port and one read port on a single clock.
- Adds per-byte write enables, a configurable read latency of 1 or 2, and a selectable read-during-write policy.
- Includes an optional self-clearing sweep after reset, with a busy flag.
- Intended as the storage element under the FIFO controllers. Replaces the combinational-access RAM.

Parameters:
- DATA_RAM_WIDTH, 8: word width in bits. Must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 8: address width. Depth DEPTH = 2^ADDR_WIDTH.
- BYTE_WIDTH, 8: bits per byte lane. Lane count NB = DATA_RAM_WIDTH/BYTE_WIDTH.
- READ_LATENCY, 1: 1 or 2 clock edges from read request to data. Any other value is an elaboration error.
- RDW_MODE, 0: same-address read/write collision policy. 0 returns old data; 1 returns new (merged) data.
- CLEAR_ON_RESET, 1: 1 zeroes every location after reset; 0 skips the sweep.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  write request
- wr_addr  input  ADDR_WIDTH  write address
- wr_data  input  DATA_RAM_WIDTH  write data
- wr_be  input  NB  byte-lane enables; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH]
- rd_en  input  1  read request
- rd_addr  input  ADDR_WIDTH  read address
- rd_data  output  DATA_RAM_WIDTH  read data
- rd_valid  output  1  one-cycle pulse, rd_data carries a new read result
- init_busy  output  1  clear sweep in progress; requests ignored

Behaviour:
- Reset (sampled at edge with reset=1):
  - rd_data=0, rd_valid=0, read pipeline flushed.
  - FSM=CLEAR with clr_cnt=0 if CLEAR_ON_RESET, else FSM=IDLE.
  - init_busy = CLEAR_ON_RESET while reset is high.
  - Memory contents are not touched while reset is high.
- FSM states: CLEAR, IDLE.
  - CLEAR: each edge with reset=0 writes 0 to mem[clr_cnt], then clr_cnt++.
  - At clr_cnt=DEPTH-1 the FSM goes to IDLE on that edge.
  - The sweep takes exactly DEPTH edges after reset deasserts; init_busy falls after the last one.
  - Reset mid-sweep restarts the sweep from address 0.
  - IDLE: init_busy=0 and the FSM stays in IDLE until the next reset.
- While init_busy=1:
  - wr_en and rd_en are ignored.
  - rd_valid stays 0.
  - No user write modifies memory.
- Write:
  - At an edge with wr_en=1, each lane i with wr_be[i]=1 takes wr_data lane i.
  - Other lanes keep their contents.
  - wr_be all-zero is a no-op.
- Read:
  - rd_en=1 sampled at edge t.
  - READ_LATENCY=1: rd_data/rd_valid update at edge t.
  - READ_LATENCY=2: rd_data/rd_valid update at edge t+1, via an internal output register.
  - Fully pipelined: back-to-back reads produce back-to-back results.
  - rd_valid is high for exactly one cycle per accepted read.
  - rd_data holds its last value when there is no new result; it is never zeroed except by reset.
- Read-during-write, same address at the same edge:
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the word as it is after the write (byte-enable merge applied).
  - Different addresses: no interaction.
- Addresses are full range; 0 and DEPTH-1 are both valid. No wrap logic is needed inside the block.
- Unwritten locations read 0 when CLEAR_ON_RESET=1 and are undefined otherwise.

Test Plan:
- Clear timing (ADDR_WIDTH=4, CLEAR_ON_RESET=1):
  - Reset high 3 cycles, then low.
  - init_busy must stay high for exactly 16 edges after deassert.
  - A wr_en during busy has no effect; reading all 16 addresses afterwards returns 0 each.
- Byte enables (DATA_RAM_WIDTH=32, RDW_MODE=0):
  - Write 0xAABBCCDD with be=1111 to addr 5, then 0x11223344 with be=0101 to addr 5.
  - A read of addr 5 must return 0xAA22CC44.
- Read-during-write on addr 3 (holding 0x12):
  - Same-edge write 0x34 and read of addr 3.
  - RDW_MODE=0 must return 0x12; RDW_MODE=1 must return 0x34.
- Latency (READ_LATENCY=2):
  - Reads of addr 0,1,2 on consecutive edges t, t+1, t+2.
  - rd_valid must be high on edges t+1..t+3 with the matching data.
  - No rd_valid may appear at edge t.
- Reset mid-sweep:
  - Assert reset at sweep count 7 for one cycle.
  - The sweep must restart from 0: init_busy high for a further DEPTH edges; rd_data=0 and rd_valid=0 after the reset edge.
- Boundary address:
  - Write 0xFF to addr DEPTH-1 and 0x01 to addr 0.
  - Reads must return 0xFF and 0x01 respectively.
  - rd_data must hold 0x01 on following idle cycles with rd_valid=0.
